stream_arb_mux: RTL and testbench

//  Registered NUM_CH:1 data-stream multiplexer with valid/ready handshake and built-in arbitration.

---
 rtl/stream_arb_mux.sv | 144 ++++++++++++++
 tb/tb_stream_arb_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: registered NUM_CH:1 valid/ready stream multiplexer with
// built-in fixed-priority / round-robin arbitration.
// Optional packet lock: define STREAM_ARB_MUX_LOCK_EN to add in_last and hold
// the grant on one channel until it sends a beat with in_last set.
module stream_arb_mux #(
  parameter int N      = 16,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_rr,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [NUM_CH*N-1:0] in_data,
`ifdef STREAM_ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]   in_last,
`endif
  output logic [NUM_CH-1:0]   in_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
  logic [SEL_W-1:0]   ptr_q,       ptr_d;
`ifdef STREAM_ARB_MUX_LOCK_EN
  logic               lock_q,      lock_d;
  logic [SEL_W-1:0]   lock_ch_q,   lock_ch_d;
`endif

  logic               load;
  logic               gnt_found;
  logic [SEL_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0]  grant;
  logic [N-1:0]       gnt_data;
  logic [SEL_W:0]     sum;
  logic [SEL_W-1:0]   cand;

  // The output register can take a new beat when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Pick the winning channel: scan from 0 (fixed) or from the pointer (rr).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (mode_rr) begin
        cand = (sum >= NUM_CH_W) ? SEL_W'(sum - NUM_CH_W) : SEL_W'(sum);
      end else begin
        cand = SEL_W'(k);
      end
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef STREAM_ARB_MUX_LOCK_EN
    // A packet in progress owns the output; nobody else may be granted.
    if (lock_q) begin
      gnt_found = in_valid[lock_ch_q];
      gnt_idx   = lock_ch_q;
    end
`endif
  end

  // Expand the winner into a one-hot grant and select its data.
  always_comb begin
    grant    = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_found && (gnt_idx == SEL_W'(i))) begin
        grant[i] = 1'b1;
        gnt_data = in_data[i*N +: N];
      end
    end
  end

  assign in_ready = load ? grant : '0;

  // Next-state for the output register, rr pointer and packet lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (load) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_data_d = gnt_data;
        out_sel_d  = gnt_idx;
`ifdef STREAM_ARB_MUX_LOCK_EN
        lock_d    = !in_last[gnt_idx];
        lock_ch_d = gnt_idx;
        if (in_last[gnt_idx]) begin
          ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SEL_W'(1);
        end
`else
        ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SEL_W'(1);
`endif
      end
    end
  end

  // State registers; reset drops any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef STREAM_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux (N=16, NUM_CH=3).
module tb_stream_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_rr;
  logic [2:0]  in_valid;
  logic [47:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef STREAM_ARB_MUX_LOCK_EN
  logic [2:0]  in_last;
`endif

  int checks = 0;
  int errors = 0;

  stream_arb_mux #(.N(16), .NUM_CH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_rr   (mode_rr),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [2:0]  vld;
    logic        ordy;
    logic [2:0]  exp_rdy;
    logic        exp_ov;
    logic [15:0] exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Check out_* one time unit after the next rising edge.
  task automatic check_out(input string tag, input logic ov, input logic [15:0] d, input logic [1:0] s);
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"},  32'(out_data),  32'(d));
    check({tag, ".out_sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                mode vld     ordy exp_rdy exp_ov data      sel
    vecs[0]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[1]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[2]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[3]  = '{1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 16'hF0F0, 2'd1};
    vecs[4]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 16'hFFFF, 2'd2};
    vecs[5]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[6]  = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 16'hF0F0, 2'd1};
    vecs[7]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 16'hFFFF, 2'd2};
    vecs[8]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[9]  = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 16'hF0F0, 2'd1};
    vecs[10] = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 16'hFFFF, 2'd2};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 16'hFFFF, 2'd2};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 16'hFFFF, 2'd2};
    vecs[13] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 16'hFFFF, 2'd2};
    vecs[14] = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[15] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 16'h0F0F, 2'd0};
    vecs[16] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 16'h0F0F, 2'd0};
    vecs[17] = '{1'b0, 3'b100, 1'b1, 3'b100, 1'b1, 16'hFFFF, 2'd2};
    vecs[18] = '{1'b1, 3'b011, 1'b1, 3'b001, 1'b1, 16'h0F0F, 2'd0};
    vecs[19] = '{1'b1, 3'b101, 1'b1, 3'b100, 1'b1, 16'hFFFF, 2'd2};
    vecs[20] = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 16'hF0F0, 2'd1};
    vecs[21] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 16'hF0F0, 2'd1};

    rst_n     = 1'b0;
    mode_rr   = 1'b0;
    in_valid  = 3'b000;
    in_data   = {16'hFFFF, 16'hF0F0, 16'h0F0F};
    out_ready = 1'b1;
`ifdef STREAM_ARB_MUX_LOCK_EN
    in_last   = 3'b111;
`endif

    // Power-on reset state.
    #3;
    check("rst0.out_valid", 32'(out_valid), 32'd0);
    check("rst0.out_data",  32'(out_data),  32'd0);
    check("rst0.out_sel",   32'(out_sel),   32'd0);
    check("rst0.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, one beat per clock.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      mode_rr   = vecs[i].mode;
      in_valid  = vecs[i].vld;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      check_out($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_sel);
    end

    // Asynchronous reset in the middle of a held beat.
    @(negedge clk);
    in_valid = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst1.out_valid", 32'(out_valid), 32'd0);
    check("rst1.out_data",  32'(out_data),  32'd0);
    check("rst1.out_sel",   32'(out_sel),   32'd0);
    check("rst1.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer was 2 before reset; RR must restart at channel 0.
    mode_rr   = 1'b1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    #1;
    check("rr_rst.in_ready", 32'(in_ready), 32'b001);
    check_out("rr_rst", 1'b1, 16'h0F0F, 2'd0);

`ifdef STREAM_ARB_MUX_LOCK_EN
    // Packet of three beats from ch1 while ch0 is waiting in fixed mode.
    @(negedge clk);
    mode_rr  = 1'b0;
    in_valid = 3'b010;
    in_last  = 3'b000;
    check_out("lock0", 1'b1, 16'hF0F0, 2'd1);
    @(negedge clk);
    in_valid = 3'b011;
    #1;
    check("lock1.in_ready", 32'(in_ready), 32'b010);
    check_out("lock1", 1'b1, 16'hF0F0, 2'd1);
    @(negedge clk);
    in_last = 3'b010;
    #1;
    check("lock2.in_ready", 32'(in_ready), 32'b010);
    check_out("lock2", 1'b1, 16'hF0F0, 2'd1);
    @(negedge clk);
    in_valid = 3'b001;
    in_last  = 3'b111;
    #1;
    check("lock3.in_ready", 32'(in_ready), 32'b001);
    check_out("lock3", 1'b1, 16'h0F0F, 2'd0);
`endif

    @(negedge clk);
    in_valid = 3'b000;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
